// File: rtl/bs_pkg.sv
// bs_pkg: shared command codes, state encodings and datapath latency constants
package bs_pkg;
  localparam logic [3:0] CMD_RUN   = 4'd1;
  localparam logic [3:0] CMD_ACK   = 4'd2;
  localparam logic [3:0] CMD_ABORT = 4'd3;
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_RUNNING  = 4'd1,
    ST_COMPLETE = 4'd2,
    ST_DRAIN    = 4'd3
  } state_t;
  localparam int MULT_LAT = 5;
  localparam int EXP_LAT  = 17;
  localparam int SUB_LAT  = 7;
  // mult -> exp -> mult -> sub -> mult
  localparam int PIPE_LAT_DEF = 3 * MULT_LAT + EXP_LAT + SUB_LAT;
endpackage

// File: rtl/bs_valid_pipe.sv
// bs_valid_pipe: valid-bit shadow of the datapath, advancing only on enabled cycles
module bs_valid_pipe #(
  parameter int DEPTH = 39
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic din,
  output logic tail,
  output logic busy
);
  logic [DEPTH-1:0] sr;
  // shift a valid bit in per enabled cycle; clear drops everything in flight
  always_ff @(posedge clk) begin
    if (clr) sr <= '0;
    else if (en) sr <= (sr << 1) | DEPTH'(din);
  end
  assign tail = sr[DEPTH-1];
  assign busy = |sr;
endmodule

// File: rtl/bs_pipe_ctrl.sv
// bs_pipe_ctrl: run controller streaming samples through a fixed-latency payoff datapath
module bs_pipe_ctrl
  import bs_pkg::*;
#(
  parameter int DW       = 32,
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int CNT_W    = 16,
  parameter bit CLAMP    = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       cmd,
  input  logic [CNT_W-1:0] num_samples,
  output logic [3:0]       status,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  output logic [DW-1:0]    dp_din,
  output logic             dp_clk_en,
  input  logic [DW-1:0]    dp_dout,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] retired
);
  state_t state, nxt;
  logic [CNT_W-1:0] num_l, issued;
  logic en, abort, hs_in, hs_out, tail, busy;
  assign en        = ~(out_valid & ~out_ready);
  assign abort     = (cmd == CMD_ABORT) && (state == ST_RUNNING || state == ST_DRAIN);
  assign in_ready  = (state == ST_RUNNING) && (issued < num_l) && en;
  assign hs_in     = in_valid & in_ready;
  assign hs_out    = out_valid & out_ready;
  assign dp_din    = in_data;
  assign dp_clk_en = en;
  assign status    = state;
  bs_valid_pipe #(.DEPTH(PIPE_LAT)) u_vld (
    .clk  (clk),
    .clr  (reset | abort),
    .en   (en),
    .din  (hs_in),
    .tail (tail),
    .busy (busy)
  );
  // next state: a run ends only once every issued sample has been delivered
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:     nxt = (cmd == CMD_RUN) ? ST_RUNNING : ST_IDLE;
      ST_RUNNING:  nxt = abort ? ST_IDLE : (issued == num_l) ? ST_DRAIN : ST_RUNNING;
      ST_DRAIN:    nxt = abort ? ST_IDLE :
                         (retired == num_l && !out_valid && !busy) ? ST_COMPLETE : ST_DRAIN;
      ST_COMPLETE: nxt = (cmd == CMD_ACK) ? ST_IDLE : ST_COMPLETE;
      default:     nxt = ST_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else state <= nxt;
  end
  // run length latch and issue/retire counters, restarted on RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      num_l   <= '0;
      issued  <= '0;
      retired <= '0;
    end else if (state == ST_IDLE) begin
      num_l <= num_samples;
      if (cmd == CMD_RUN) begin
        issued  <= '0;
        retired <= '0;
      end
    end else begin
      if (hs_in) issued <= issued + 1'b1;
      if (hs_out) retired <= retired + 1'b1;
    end
  end
  // output register: reload on retire, drop valid once taken, flush on abort
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (abort) out_valid <= 1'b0;
    else if (en && tail) begin
      out_valid <= 1'b1;
      out_data  <= (CLAMP && dp_dout[DW-1]) ? '0 : dp_dout;
    end else if (hs_out) out_valid <= 1'b0;
  end
endmodule

// File: tb/tb_bs_pipe_ctrl.sv
// tb_bs_pipe_ctrl: directed vectors against a delay-line datapath model
module tb_bs_pipe_ctrl;
  localparam int PL = 39;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] cmd = 4'd0;
  logic [15:0] num_samples = 16'd0;
  logic [3:0] status;
  logic in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic in_ready;
  logic [31:0] dp_din;
  logic dp_clk_en;
  logic [31:0] dp_dout;
  logic out_valid;
  logic [31:0] out_data;
  logic out_ready = 1'b1;
  logic [15:0] retired;
  logic [31:0] dl [PL];
  logic [31:0] feed[$], sb[$], got_q[$];
  logic [31:0] exp_d;
  int n_vec = 0, n_err = 0;
  int first_hs, last_hs, first_ov, n_hs, n_out, n_stall, en_bad, cnt;
  bit done, found;

  bs_pipe_ctrl #(.DW(32), .PIPE_LAT(PL), .CNT_W(16), .CLAMP(1'b1)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .num_samples(num_samples), .status(status),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .dp_din(dp_din),
    .dp_clk_en(dp_clk_en), .dp_dout(dp_dout), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .retired(retired)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) for (int i = 0; i < PL; i++) dl[i] <= 32'd0;
    else if (dp_clk_en) begin
      for (int i = PL - 1; i > 0; i--) dl[i] <= dl[i-1];
      dl[0] <= dp_din;
    end
  end
  assign dp_dout = dl[PL-1];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] clampf(input logic [31:0] x);
    return x[31] ? 32'h0 : x;
  endfunction

  task automatic do_run(input int num, input bit toggle, input int budget);
    num_samples = 16'(num);
    cmd = 4'd1;
    tick;
    cmd = 4'd0;
    first_hs = -1; last_hs = -1; first_ov = -1;
    n_hs = 0; n_out = 0; n_stall = 0; en_bad = 0; done = 0;
    got_q.delete();
    sb.delete();
    for (int c = 0; c < budget && !done; c++) begin
      out_ready = toggle ? (c % 2 == 0) : 1'b1;
      in_valid = feed.size() > 0;
      in_data = in_valid ? feed[0] : 32'h0;
      #1;
      if (status == 4'd2) done = 1;
      else begin
        if (dp_clk_en !== !(out_valid && !out_ready)) en_bad++;
        if (out_valid && !out_ready) n_stall++;
        if (out_valid && first_ov < 0) first_ov = c;
        if (in_valid && in_ready) begin
          if (first_hs < 0) first_hs = c;
          last_hs = c;
          n_hs++;
          sb.push_back(clampf(feed.pop_front()));
        end
        if (out_valid && out_ready) begin
          n_out++;
          got_q.push_back(out_data);
          exp_d = sb.size() > 0 ? sb.pop_front() : 32'hDEADDEAD;
          chk("out data", out_data, exp_d);
        end
        tick;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("run completes", 32'(done), 32'd1);
  endtask

  initial begin
    repeat (2) tick;
    chk("rst status", 32'(status), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst retired", 32'(retired), 32'd0);
    reset = 1'b0;
    tick;

    for (int i = 0; i < 4; i++) feed.push_back(32'h3F800000 + 32'(i));
    do_run(4, 1'b0, 200);
    chk("t1 handshakes", 32'(n_hs), 32'd4);
    chk("t1 consecutive", 32'(last_hs - first_hs), 32'd3);
    chk("t1 latency", 32'(first_ov - first_hs), 32'(PL + 1));
    chk("t1 retired", 32'(retired), 32'd4);
    chk("t1 status", 32'(status), 32'd2);
    chk("t1 en", 32'(en_bad), 32'd0);
    cmd = 4'd2;
    tick;
    cmd = 4'd0;
    chk("t1 ack", 32'(status), 32'd0);

    for (int i = 0; i < 8; i++) feed.push_back(32'h41000000 + 32'(i * 3));
    do_run(8, 1'b1, 400);
    chk("t2 outputs", 32'(n_out), 32'd8);
    chk("t2 retired", 32'(retired), 32'd8);
    chk("t2 en", 32'(en_bad), 32'd0);
    chk("t2 stalled", 32'(n_stall > 0), 32'd1);
    cmd = 4'd2;
    tick;
    cmd = 4'd0;

    feed.push_back(32'hBF800000);
    feed.push_back(32'h40000000);
    do_run(2, 1'b0, 200);
    chk("t3 outputs", 32'(n_out), 32'd2);
    chk("t3 neg", got_q[0], 32'h0);
    chk("t3 pos", got_q[1], 32'h40000000);
    cmd = 4'd2;
    tick;
    cmd = 4'd0;

    num_samples = 16'd0;
    in_valid = 1'b1;
    cmd = 4'd1;
    tick;
    cmd = 4'd0;
    chk("t4 running", 32'(status), 32'd1);
    chk("t4 in_ready", 32'(in_ready), 32'd0);
    tick;
    chk("t4 drain", 32'(status), 32'd3);
    chk("t4 in_ready2", 32'(in_ready), 32'd0);
    tick;
    chk("t4 complete", 32'(status), 32'd2);
    chk("t4 retired", 32'(retired), 32'd0);
    in_valid = 1'b0;
    cmd = 4'd2;
    tick;
    cmd = 4'd0;

    num_samples = 16'd20;
    cmd = 4'd1;
    tick;
    cmd = 4'd0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data = 32'h3F000000 + 32'(c);
      #1;
      if (in_ready) cnt++;
      tick;
    end
    chk("t5 handshakes", 32'(cnt), 32'd10);
    in_valid = 1'b0;
    cmd = 4'd3;
    tick;
    cmd = 4'd0;
    chk("t5 idle", 32'(status), 32'd0);
    chk("t5 out_valid", 32'(out_valid), 32'd0);
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (out_valid) cnt++;
      tick;
    end
    chk("t5 no stale", 32'(cnt), 32'd0);
    feed.push_back(32'h40400000);
    feed.push_back(32'h40800000);
    do_run(2, 1'b0, 200);
    chk("t5 rerun retired", 32'(retired), 32'd2);
    chk("t5 rerun outputs", 32'(n_out), 32'd2);
    cmd = 4'd2;
    tick;
    cmd = 4'd0;

    num_samples = 16'd1;
    cmd = 4'd1;
    tick;
    cmd = 4'd0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h3F800000;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (out_valid) found = 1;
      else tick;
    end
    chk("t6 out_valid", 32'(found), 32'd1);
    chk("t6 drain", 32'(status), 32'd3);
    chk("t6 data", out_data, 32'h3F800000);
    reset = 1'b1;
    tick;
    chk("t6 rst status", 32'(status), 32'd0);
    chk("t6 rst out_valid", 32'(out_valid), 32'd0);
    chk("t6 rst out_data", out_data, 32'd0);
    chk("t6 rst retired", 32'(retired), 32'd0);
    chk("t6 rst in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cmd = 4'd2;
    tick;
    chk("t6 ack in idle", 32'(status), 32'd0);
    num_samples = 16'd0;
    cmd = 4'd1;
    repeat (3) tick;
    chk("t6 complete", 32'(status), 32'd2);
    tick;
    chk("t6 run in complete", 32'(status), 32'd2);
    cmd = 4'd2;
    tick;
    cmd = 4'd0;
    chk("t6 final ack", 32'(status), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
